// File: rtl/cv_pkg.sv
// Shared definitions for the commitment packer and the SM3 hasher it drives.
package cv_pkg;

    localparam int DIGEST_W = 256;
    localparam int BLK_W    = 512;
    localparam int RIDX_W   = 8;

    // SM3 initial hash value; the hasher seeds its chaining state from this.
    localparam logic [DIGEST_W-1:0] SM3_IV =
        256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        REL,
        FLUSH,
        DONE
    } cv_state_t;

    // FIFO entry layout: bit BLK_W is the last-block flag, below it the block.
    function automatic logic [BLK_W:0] pack_entry(input logic last,
                                                  input logic [DIGEST_W-1:0] even_d,
                                                  input logic [DIGEST_W-1:0] odd_d);
        return {last, even_d, odd_d};
    endfunction

endpackage

// File: rtl/cv_blk_fifo.sv
// First-word-fall-through buffer of packed 512-bit blocks plus a last flag.
// The head entry is visible on pop_data whenever empty is low; there is no
// bypass, so a pushed entry appears one cycle after the push edge.
module cv_blk_fifo
    import cv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [BLK_W:0]           push_data,
    input  logic                     pop,
    output logic [BLK_W:0]           pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BLK_W:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && !full;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cv_commit_packer.sv
// Sequences one SM3 hasher request per round, pairs consecutive digests into
// 512-bit blocks and streams them to the challenge-hash stage.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for run_start
// CHECK | decide whether the next request may issue (odd index needs a free slot)
// REQ   | hash_start high, waiting for hash_done; capture or push the digest
// REL   | hash_start low for one cycle so the hasher drops its done flag
// FLUSH | all digests taken, waiting for the FIFO to drain
// DONE  | one-cycle run_done pulse, then back to IDLE
module cv_commit_packer
    import cv_pkg::*;
#(
    parameter int NUM_ROUNDS = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run_start,
    output logic                 hash_start,
    input  logic                 hash_done,
    input  logic [DIGEST_W-1:0]  hash_value,
    output logic [RIDX_W-1:0]    round_idx,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic [BLK_W-1:0]     blk_data,
    output logic                 blk_last,
    output logic                 busy,
    output logic                 run_done
);

    localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NUM_ROUNDS - 1);

    cv_state_t           state;
    logic [DIGEST_W-1:0] half_reg;
    logic                fifo_push;
    logic [BLK_W:0]      fifo_wdata;
    logic [BLK_W:0]      fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                odd_idx;

    assign odd_idx    = round_idx[0];
    assign fifo_push  = (state == REQ) && hash_done && odd_idx && !fifo_full;
    assign fifo_wdata = pack_entry(round_idx == LAST_IDX, half_reg, hash_value);

    assign blk_valid  = !fifo_empty;
    assign blk_last   = fifo_head[BLK_W];
    assign blk_data   = fifo_head[BLK_W-1:0];

    cv_blk_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (blk_ready),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Run sequencer with registered hash_start/busy/run_done decodes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hash_start <= 1'b0;
            round_idx  <= '0;
            half_reg   <= '0;
            busy       <= 1'b0;
            run_done   <= 1'b0;
        end else begin
            run_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (run_start) begin
                        round_idx <= '0;
                        busy      <= 1'b1;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    // An odd request completes a block, so reserve its slot now.
                    if (!odd_idx || (fifo_count < CNT_W'(FIFO_DEPTH))) begin
                        hash_start <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (hash_done) begin
                        if (!odd_idx) begin
                            half_reg <= hash_value;
                        end
                        hash_start <= 1'b0;
                        state      <= REL;
                    end
                end
                REL: begin
                    if (round_idx == LAST_IDX) begin
                        state <= FLUSH;
                    end else begin
                        round_idx <= round_idx + RIDX_W'(1);
                        state     <= CHECK;
                    end
                end
                FLUSH: begin
                    if (fifo_empty) begin
                        run_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    hash_start <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cv_commit_packer.sv
// Bench for cv_commit_packer: three instances (2, 12 and 8 rounds), each with
// a level-handshake hasher model, a block scoreboard and protocol monitors.
module tb_cv_commit_packer;

    typedef logic [512:0] ent_t;

    typedef struct {
        int inst;
        int lat;
        int mode;   // 0 ready high, 1 toggle, 2 random, 3 low
        int nblk;
    } vec_t;

    logic clk;

    logic         reset_w      [3];
    logic         run_start_w  [3];
    logic         hash_start_w [3];
    logic         hash_done_w  [3];
    logic [255:0] hash_value_w [3];
    logic [7:0]   round_idx_w  [3];
    logic         blk_valid_w  [3];
    logic         blk_ready_w  [3];
    logic [511:0] blk_data_w   [3];
    logic         blk_last_w   [3];
    logic         busy_w       [3];
    logic         run_done_w   [3];

    int lat      [3];
    int mode     [3];
    int cur_run  [3];
    int exp_idx  [3];
    int popped   [3];
    int ndone    [3];
    int last_pop [3];
    int next_run;
    int cyc;
    int n_cmp;
    int n_fail;

    ent_t sbq [3][$];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] digest(input int run, input int idx);
        logic [7:0]   b;
        logic [255:0] d;
        b = 8'((idx + 1) * 17);
        d = {32{b}};
        d[135:128] = d[135:128] ^ 8'(run);
        return d;
    endfunction

    function automatic int nr_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 12 : 8);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // blk_ready pattern per instance, changed just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 3; g++) begin
                case (mode[g])
                    0:       blk_ready_w[g] = 1'b1;
                    1:       blk_ready_w[g] = !blk_ready_w[g];
                    2:       blk_ready_w[g] = 1'($urandom_range(0, 1));
                    default: blk_ready_w[g] = 1'b0;
                endcase
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_u
        localparam int NR = (g == 0) ? 2 : ((g == 1) ? 12 : 8);

        cv_commit_packer #(
            .NUM_ROUNDS (NR),
            .FIFO_DEPTH (4)
        ) u_dut (
            .clk        (clk),
            .reset      (reset_w[g]),
            .run_start  (run_start_w[g]),
            .hash_start (hash_start_w[g]),
            .hash_done  (hash_done_w[g]),
            .hash_value (hash_value_w[g]),
            .round_idx  (round_idx_w[g]),
            .blk_valid  (blk_valid_w[g]),
            .blk_ready  (blk_ready_w[g]),
            .blk_data   (blk_data_w[g]),
            .blk_last   (blk_last_w[g]),
            .busy       (busy_w[g]),
            .run_done   (run_done_w[g])
        );

        int hcnt;

        // hasher: done rises lat cycles after start, holds until start drops
        always @(posedge clk) begin
            if (!hash_start_w[g]) begin
                hcnt           <= 0;
                hash_done_w[g] <= 1'b0;
            end else if (!hash_done_w[g]) begin
                if (hcnt >= lat[g] - 1) begin
                    hash_done_w[g]  <= 1'b1;
                    hash_value_w[g] <= digest(cur_run[g], int'(round_idx_w[g]));
                end else begin
                    hcnt <= hcnt + 1;
                end
            end
        end

        logic         p_hold;
        logic         p_dh;
        logic         p_hs;
        logic [511:0] p_data;
        logic         p_last;

        always @(negedge clk) begin
            if (reset_w[g]) begin
                p_hold = 1'b0;
                p_dh   = 1'b0;
                p_hs   = 1'b0;
            end else begin
                if (p_hold) begin
                    check($sformatf("u%0d_hold_valid", g), blk_valid_w[g], 1);
                    check($sformatf("u%0d_hold_data", g), blk_data_w[g], p_data);
                    check($sformatf("u%0d_hold_last", g), blk_last_w[g], p_last);
                end
                if (blk_valid_w[g] && blk_ready_w[g]) begin
                    if (sbq[g].size() == 0) begin
                        check($sformatf("u%0d_extra_blk", g), 1, 0);
                    end else begin
                        ent_t e;
                        e = sbq[g].pop_front();
                        check($sformatf("u%0d_blk_data", g), blk_data_w[g], e[511:0]);
                        check($sformatf("u%0d_blk_last", g), blk_last_w[g], e[512]);
                    end
                    popped[g]++;
                    last_pop[g] = cyc;
                end
                if (p_dh) begin
                    check($sformatf("u%0d_release", g), hash_start_w[g], 0);
                end
                if (hash_start_w[g] && !p_hs) begin
                    check($sformatf("u%0d_round_idx", g), round_idx_w[g], exp_idx[g]);
                    exp_idx[g]++;
                end
                if (run_done_w[g]) begin
                    ndone[g]++;
                    // last pop completes at the next edge; FLUSH sees empty one edge later
                    check($sformatf("u%0d_done_after_pop", g), cyc, last_pop[g] + 2);
                    check($sformatf("u%0d_done_busy", g), busy_w[g], 1);
                    check($sformatf("u%0d_done_sb_empty", g), sbq[g].size(), 0);
                end
                p_hold = blk_valid_w[g] && !blk_ready_w[g];
                p_data = blk_data_w[g];
                p_last = blk_last_w[g];
                p_dh   = hash_done_w[g] && hash_start_w[g];
                p_hs   = hash_start_w[g];
            end
        end
    end

    task automatic start_run(input int g);
        int nr;
        nr = nr_of(g);
        cur_run[g] = next_run;
        next_run++;
        for (int k = 0; k < nr / 2; k++) begin
            sbq[g].push_back({(k == nr / 2 - 1), digest(cur_run[g], 2 * k),
                              digest(cur_run[g], 2 * k + 1)});
        end
        exp_idx[g] = 0;
        popped[g]  = 0;
        ndone[g]   = 0;
        @(posedge clk);
        #1 run_start_w[g] = 1'b1;
        @(posedge clk);
        #1 run_start_w[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget, input string name);
        int t;
        int nr;
        t  = 0;
        nr = nr_of(g);
        while (ndone[g] == 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        if (ndone[g] == 0) check({name, "_timeout"}, 0, 1);
        repeat (3) @(negedge clk);
        check({name, "_busy_idle"}, busy_w[g], 0);
        check({name, "_nblk"}, popped[g], nr / 2);
        check({name, "_sb_empty"}, sbq[g].size(), 0);
        check({name, "_req_count"}, exp_idx[g], nr);
        check({name, "_ndone"}, ndone[g], 1);
    endtask

    task automatic wait_req_at(input int g, input int idx, input string name);
        int t;
        t = 0;
        while (!(round_idx_w[g] == 8'(idx) && hash_start_w[g]) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check({name, "_reach_timeout"}, 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t tbl [5];
        tbl[0] = '{inst: 0, lat: 10, mode: 0, nblk: 1};
        tbl[1] = '{inst: 2, lat: 3,  mode: 1, nblk: 4};
        tbl[2] = '{inst: 2, lat: 1,  mode: 0, nblk: 4};
        tbl[3] = '{inst: 1, lat: 2,  mode: 2, nblk: 6};
        tbl[4] = '{inst: 0, lat: 1,  mode: 2, nblk: 1};

        n_cmp    = 0;
        n_fail   = 0;
        next_run = 0;
        for (int g = 0; g < 3; g++) begin
            reset_w[g]     = 1'b1;
            run_start_w[g] = 1'b0;
            blk_ready_w[g] = 1'b0;
            lat[g]         = 4;
            mode[g]        = 3;
            cur_run[g]     = 0;
            exp_idx[g]     = 0;
            popped[g]      = 0;
            ndone[g]       = 0;
            last_pop[g]    = 0;
        end

        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst%0d_hash_start", g), hash_start_w[g], 0);
            check($sformatf("rst%0d_round_idx", g), round_idx_w[g], 0);
            check($sformatf("rst%0d_blk_valid", g), blk_valid_w[g], 0);
            check($sformatf("rst%0d_blk_last", g), blk_last_w[g], 0);
            check($sformatf("rst%0d_busy", g), busy_w[g], 0);
            check($sformatf("rst%0d_run_done", g), run_done_w[g], 0);
            reset_w[g] = 1'b0;
        end

        // table-driven complete runs
        for (int i = 0; i < 5; i++) begin
            lat[tbl[i].inst]  = tbl[i].lat;
            mode[tbl[i].inst] = tbl[i].mode;
            start_run(tbl[i].inst);
            wait_done(tbl[i].inst, 3000, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_tbl_nblk", i), popped[tbl[i].inst], tbl[i].nblk);
            mode[tbl[i].inst] = 3;
        end

        // 12 rounds into a 4-deep FIFO with the consumer stalled
        lat[1]  = 10;
        mode[1] = 3;
        start_run(1);
        repeat (300) @(negedge clk);
        check("stall_round_idx", round_idx_w[1], 9);
        check("stall_hash_start", hash_start_w[1], 0);
        check("stall_busy", busy_w[1], 1);
        check("stall_valid", blk_valid_w[1], 1);
        check("stall_popped", popped[1], 0);
        repeat (50) @(negedge clk);
        check("stall_hold_idx", round_idx_w[1], 9);
        check("stall_hold_start", hash_start_w[1], 0);
        mode[1] = 0;
        wait_done(1, 3000, "stall");

        // run_start while in REQ at round 3 must be ignored
        lat[2]  = 4;
        mode[2] = 0;
        start_run(2);
        wait_req_at(2, 3, "ign");
        run_start_w[2] = 1'b1;
        @(negedge clk);
        run_start_w[2] = 1'b0;
        wait_done(2, 3000, "ign");
        repeat (150) @(negedge clk);
        check("ign_single_done", ndone[2], 1);
        check("ign_idle_busy", busy_w[2], 0);

        // reset in REQ at round 5 with two blocks buffered
        lat[2]  = 4;
        mode[2] = 3;
        start_run(2);
        wait_req_at(2, 5, "mrst");
        check("mrst_pre_valid", blk_valid_w[2], 1);
        #1 reset_w[2] = 1'b1;
        @(negedge clk);
        check("mrst_hash_start", hash_start_w[2], 0);
        check("mrst_blk_valid", blk_valid_w[2], 0);
        check("mrst_busy", busy_w[2], 0);
        check("mrst_round_idx", round_idx_w[2], 0);
        check("mrst_run_done", run_done_w[2], 0);
        sbq[2].delete();
        @(posedge clk);
        #1 reset_w[2] = 1'b0;
        mode[2] = 0;
        start_run(2);
        wait_done(2, 3000, "mrst_fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
